reward_table_engine: RTL and testbench

Parametrised successor to the single-shot reward unit in the clustering Q-learning datapath. It accepts one received-packet descriptor per `en` pulse and keeps a `DEPTH`-entry neighbour table holding source ID, battery and Q-value. It computes a fixed-point reward with a cluster-membership penalty and tracks the best next hop. It sits between the packet-field extractor and the Q-value update stage.

---
 rtl/reward_table_engine.sv | 199 +++++++++++++++++++
 tb/tb_reward_table_engine.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/reward_table_engine.sv
// Neighbour-table reward engine: scans a DEPTH-entry table for the packet sender, updates or allocates the entry, and emits a saturating fixed-point reward.
// Optional best-next-hop tracking is built when REWARD_BEST_HOP_EN is defined.
`timescale 1ns/1ps

module reward_table_engine #(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned FRAC = WORD_WIDTH - 1,
    parameter int unsigned DEPTH = 8,
    parameter logic [WORD_WIDTH-1:0] HOP_PENALTY = WORD_WIDTH'(16'h0100)
) (
    input  logic                          clock,
    input  logic                          nrst,
    input  logic                          en,
    input  logic [WORD_WIDTH-1:0]         fsourceID,
    input  logic [WORD_WIDTH-1:0]         fbatteryStat,
    input  logic [WORD_WIDTH-1:0]         fValue,
    input  logic [WORD_WIDTH-1:0]         fclusterID,
    input  logic [WORD_WIDTH-1:0]         fdestinationID,
    input  logic [WORD_WIDTH-1:0]         my_cluster_id,
    output logic                          busy,
    output logic [WORD_WIDTH-1:0]         reward_out,
    output logic                          done_reward,
    output logic                          hit,
    output logic [$clog2(DEPTH+1)-1:0]    table_count,
    output logic [WORD_WIDTH-1:0]         best_id,
    output logic [WORD_WIDTH-1:0]         best_reward
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = 2 * WORD_WIDTH;

    typedef enum logic [1:0] {IDLE, SCAN, UPDATE, DONE} state_t;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] id;
        logic [WORD_WIDTH-1:0] batt;
        logic [WORD_WIDTH-1:0] qval;
        logic [WORD_WIDTH-1:0] dest;
    } entry_t;

    state_t state_q, state_d;
    logic   busy_d, done_d;

    entry_t             tab [DEPTH];
    logic [DEPTH-1:0]   valid_q;

    logic [WORD_WIDTH-1:0] src_q, batt_q, val_q, cl_q, dest_q;
    logic [IW-1:0]         idx_q, match_idx_q, rep_q;
    logic                  match_q;
    logic [CW-1:0]         count_q;

    logic                  accept_c, last_scan_c, compare_c, full_c;
    logic [IW-1:0]         widx_c;
    logic [PW-1:0]         prod_c, p_full_c;
    logic [WORD_WIDTH-1:0] p_sat_c, reward_c;

    // FSM state register
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            busy        <= 1'b0;
            done_reward <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy        <= busy_d;
            done_reward <= done_d;
        end
    end

    // Next state plus next values of the registered busy/done flags
    always_comb begin
        state_d = state_q;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = en;
                if (en) state_d = SCAN;
            end
            SCAN: begin
                if (last_scan_c) state_d = UPDATE;
            end
            UPDATE: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Scan compare, write-slot selection and reward arithmetic
    always_comb begin
        accept_c    = (state_q == IDLE) && en;
        last_scan_c = (idx_q == IW'(DEPTH - 1));
        compare_c   = valid_q[idx_q] && (tab[idx_q].id == src_q);
        full_c      = (count_q == CW'(DEPTH));
        if (match_q)     widx_c = match_idx_q;
        else if (full_c) widx_c = rep_q;
        else             widx_c = IW'(count_q);

        prod_c   = PW'(batt_q) * PW'(val_q);
        p_full_c = prod_c >> FRAC;
        p_sat_c  = (|p_full_c[PW-1:WORD_WIDTH]) ? '1 : p_full_c[WORD_WIDTH-1:0];
        if (cl_q == my_cluster_id)     reward_c = p_sat_c;
        else if (p_sat_c > HOP_PENALTY) reward_c = p_sat_c - HOP_PENALTY;
        else                            reward_c = '0;
    end

    // Packet latch, scan bookkeeping and table maintenance
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) tab[i] <= '0;
            valid_q     <= '0;
            src_q       <= '0;
            batt_q      <= '0;
            val_q       <= '0;
            cl_q        <= '0;
            dest_q      <= '0;
            idx_q       <= '0;
            match_idx_q <= '0;
            match_q     <= 1'b0;
            rep_q       <= '0;
            count_q     <= '0;
            reward_out  <= '0;
            hit         <= 1'b0;
        end else begin
            if (accept_c) begin
                src_q       <= fsourceID;
                batt_q      <= fbatteryStat;
                val_q       <= fValue;
                cl_q        <= fclusterID;
                dest_q      <= fdestinationID;
                idx_q       <= '0;
                match_q     <= 1'b0;
                match_idx_q <= '0;
            end
            if (state_q == SCAN) begin
                idx_q <= last_scan_c ? '0 : idx_q + IW'(1);
                if (compare_c) begin
                    match_q     <= 1'b1;
                    match_idx_q <= idx_q;
                end
            end
            if (state_q == UPDATE) begin
                tab[widx_c]     <= '{id: src_q, batt: batt_q, qval: val_q, dest: dest_q};
                valid_q[widx_c] <= 1'b1;
                reward_out      <= reward_c;
                hit             <= match_q;
                if (!match_q) begin
                    if (!full_c) count_q <= count_q + CW'(1);
                    else         rep_q   <= (rep_q == IW'(DEPTH - 1)) ? '0 : rep_q + IW'(1);
                end
            end
        end
    end

    assign table_count = count_q;

`ifdef REWARD_BEST_HOP_EN
    logic                  evict_best_c;
    logic [WORD_WIDTH-1:0] cur_best_c;
    logic [WORD_WIDTH-1:0] best_id_q, best_reward_q;

    // An evicted best hop no longer counts, so the new entry competes against zero
    always_comb begin
        evict_best_c = !match_q && full_c && valid_q[rep_q] && (tab[rep_q].id == best_id_q);
        cur_best_c   = evict_best_c ? '0 : best_reward_q;
    end

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            best_id_q     <= '0;
            best_reward_q <= '0;
        end else if (state_q == UPDATE) begin
            if ((reward_c > cur_best_c) || (src_q == best_id_q)) begin
                best_id_q     <= src_q;
                best_reward_q <= reward_c;
            end else if (evict_best_c) begin
                best_reward_q <= '0;
            end
        end
    end

    assign best_id     = best_id_q;
    assign best_reward = best_reward_q;
`else
    assign best_id     = '0;
    assign best_reward = '0;
`endif

endmodule

// File: tb/tb_reward_table_engine.sv
// Directed bench for reward_table_engine: vector table for reward/hit/count, plus sequences for
// table fill/eviction, en while busy, reset during SCAN and best-hop tracking.
`timescale 1ns/1ps

module tb_reward_table_engine;

    localparam int unsigned W     = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clock = 1'b0;
    logic          nrst  = 1'b0;
    logic          en    = 1'b0;
    logic [W-1:0]  fsourceID = '0, fbatteryStat = '0, fValue = '0;
    logic [W-1:0]  fclusterID = '0, fdestinationID = '0, my_cluster_id = 16'd1;
    logic          busy, done_reward, hit;
    logic [W-1:0]  reward_out, best_id, best_reward;
    logic [CW-1:0] table_count;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    reward_table_engine #(.WORD_WIDTH(W), .FRAC(W-1), .DEPTH(DEPTH), .HOP_PENALTY(16'h0100)) dut (
        .clock(clock), .nrst(nrst), .en(en),
        .fsourceID(fsourceID), .fbatteryStat(fbatteryStat), .fValue(fValue),
        .fclusterID(fclusterID), .fdestinationID(fdestinationID), .my_cluster_id(my_cluster_id),
        .busy(busy), .reward_out(reward_out), .done_reward(done_reward), .hit(hit),
        .table_count(table_count), .best_id(best_id), .best_reward(best_reward)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (done_reward) done_cnt++;

    typedef struct {
        logic [W-1:0] src, batt, val, cl, exp_r;
        logic         exp_h;
        int           exp_cnt;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        en   = 1'b0;
        #13;
        @(negedge clock);
        nrst = 1'b1;
    endtask

    // Sends one packet; optionally pulses en again on cycle 'inject' after acceptance
    task automatic send(input logic [W-1:0] src, batt, val, cl, input int inject,
                        output logic [W-1:0] r, output logic h);
        int lat;
        for (int i = 0; i < 50 && busy; i++) @(negedge clock);
        chk("idle_before_send", 32'(busy), 32'd0);
        @(negedge clock);
        fsourceID = src; fbatteryStat = batt; fValue = val;
        fclusterID = cl; fdestinationID = src + 16'd1;
        en = 1'b1;
        @(posedge clock);
        #1;
        en = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clock);
            #1;
            en = (c == inject);
            if (en) fsourceID = src ^ 16'h00F0;
            if (done_reward) begin
                lat = c;
                break;
            end
        end
        chk("done_latency", 32'(lat), 32'(DEPTH + 1));
        r = reward_out;
        h = hit;
        @(posedge clock);
        #1;
        en = 1'b0;
        chk("done_one_cycle", 32'(done_reward), 32'd0);
        chk("busy_cleared", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [W-1:0] r;
        logic         h;
        int           d0;

        vecs[0] = '{src:16'd15, batt:16'h4000, val:16'h0680, cl:16'd1, exp_r:16'h0340, exp_h:1'b0, exp_cnt:1};
        vecs[1] = '{src:16'd15, batt:16'h4000, val:16'h0680, cl:16'd2, exp_r:16'h0240, exp_h:1'b1, exp_cnt:1};
        vecs[2] = '{src:16'd15, batt:16'h0100, val:16'h0680, cl:16'd2, exp_r:16'h0000, exp_h:1'b1, exp_cnt:1};
        vecs[3] = '{src:16'd15, batt:16'h5999, val:16'h0680, cl:16'd1, exp_r:16'h048C, exp_h:1'b1, exp_cnt:1};
        vecs[4] = '{src:16'd20, batt:16'hFFFF, val:16'hFFFF, cl:16'd1, exp_r:16'hFFFF, exp_h:1'b0, exp_cnt:2};
        vecs[5] = '{src:16'd21, batt:16'hFFFF, val:16'hFFFF, cl:16'd2, exp_r:16'hFEFF, exp_h:1'b0, exp_cnt:3};

        // Reset values
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done_reward), 32'd0);
        chk("rst_reward", 32'(reward_out), 32'd0);
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_count", 32'(table_count), 32'd0);
        chk("rst_best_id", 32'(best_id), 32'd0);
        chk("rst_best_reward", 32'(best_reward), 32'd0);
        @(negedge clock);
        nrst = 1'b1;

        // Vector table
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].src, vecs[i].batt, vecs[i].val, vecs[i].cl, -1, r, h);
            chk($sformatf("vec%0d_reward", i), 32'(r), 32'(vecs[i].exp_r));
            chk($sformatf("vec%0d_hit", i), 32'(h), 32'(vecs[i].exp_h));
            chk($sformatf("vec%0d_count", i), 32'(table_count), 32'(vecs[i].exp_cnt));
        end

        // Fill past capacity: ids 100..109, oldest two get evicted
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) begin
            send(16'(100 + i), 16'h8000, 16'(i + 1), 16'd1, -1, r, h);
            chk($sformatf("fill%0d_reward", i), 32'(r), 32'(i + 1));
            chk($sformatf("fill%0d_hit", i), 32'(h), 32'd0);
            chk($sformatf("fill%0d_count", i), 32'(table_count), 32'((i + 1 < DEPTH) ? i + 1 : DEPTH));
        end
        send(16'd100, 16'h8000, 16'h0077, 16'd1, -1, r, h);
        chk("evicted100_hit", 32'(h), 32'd0);
        chk("evicted100_reward", 32'(r), 32'h77);
        send(16'd101, 16'h8000, 16'h0033, 16'd1, -1, r, h);
        chk("evicted101_hit", 32'(h), 32'd0);
        send(16'd109, 16'h8000, 16'h0011, 16'd1, -1, r, h);
        chk("resident109_hit", 32'(h), 32'd1);
        chk("full_count", 32'(table_count), 32'(DEPTH));

        // en while busy (SCAN) and during DONE is ignored
        do_reset();
        d0 = done_cnt;
        send(16'd50, 16'h4000, 16'h0680, 16'd1, 3, r, h);
        chk("busy_en_reward", 32'(r), 32'h0340);
        send(16'd52, 16'h8000, 16'h0010, 16'd1, DEPTH + 1, r, h);
        repeat (DEPTH + 4) @(posedge clock);
        #1;
        chk("busy_en_idle", 32'(busy), 32'd0);
        chk("busy_en_count", 32'(table_count), 32'd2);
        chk("busy_en_dones", 32'(done_cnt - d0), 32'd2);

        // Reset asserted during SCAN
        for (int i = 0; i < 50 && busy; i++) @(negedge clock);
        @(negedge clock);
        fsourceID = 16'd60; fbatteryStat = 16'h4000; fValue = 16'h0680; fclusterID = 16'd1;
        en = 1'b1;
        @(posedge clock);
        #1;
        en = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        nrst = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_reward", 32'(reward_out), 32'd0);
        chk("midrst_hit", 32'(hit), 32'd0);
        chk("midrst_count", 32'(table_count), 32'd0);
        chk("midrst_done", 32'(done_reward), 32'd0);
        @(negedge clock);
        nrst = 1'b1;
        d0 = done_cnt;
        repeat (DEPTH + 4) @(posedge clock);
        #1;
        chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        send(16'd50, 16'h4000, 16'h0680, 16'd1, -1, r, h);
        chk("midrst_next_hit", 32'(h), 32'd0);
        chk("midrst_next_count", 32'(table_count), 32'd1);

        // Best-hop tracking
        do_reset();
        send(16'd3, 16'h4000, 16'h0680, 16'd1, -1, r, h);
`ifdef REWARD_BEST_HOP_EN
        chk("best1_id", 32'(best_id), 32'd3);
        chk("best1_reward", 32'(best_reward), 32'h0340);
`else
        chk("best1_id", 32'(best_id), 32'd0);
        chk("best1_reward", 32'(best_reward), 32'd0);
`endif
        send(16'd5, 16'h5999, 16'h0680, 16'd1, -1, r, h);
        chk("best2_src_reward", 32'(r), 32'h048C);
`ifdef REWARD_BEST_HOP_EN
        chk("best2_id", 32'(best_id), 32'd5);
        chk("best2_reward", 32'(best_reward), 32'h048C);
`else
        chk("best2_id", 32'(best_id), 32'd0);
        chk("best2_reward", 32'(best_reward), 32'd0);
`endif
        send(16'd5, 16'h8000, 16'h0100, 16'd1, -1, r, h);
        chk("best3_src_reward", 32'(r), 32'h0100);
`ifdef REWARD_BEST_HOP_EN
        chk("best3_id", 32'(best_id), 32'd5);
        chk("best3_reward", 32'(best_reward), 32'h0100);
`else
        chk("best3_id", 32'(best_id), 32'd0);
        chk("best3_reward", 32'(best_reward), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
